// File: rtl/pb_pkg.sv
// Shared protobuf-parser types: varint error codes, FSM states and the ZigZag helper.
package pb_pkg;

  localparam int MAX_VARINT_BYTES = 10;

  typedef enum logic [1:0] {
    VARINT_OK        = 2'd0,
    VARINT_OVERFLOW  = 2'd1,
    VARINT_TRUNCATED = 2'd2
  } varint_err_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SKIP  = 2'd2
  } varint_state_e;

  // Callers zero-extend narrower values and keep the low bits of the result.
  function automatic logic [63:0] zigzag_decode(input logic [63:0] acc);
    return (acc >> 1) ^ {64{acc[0]}};
  endfunction

endpackage

// File: rtl/pb_varint_accum.sv
// Varint shift/OR datapath: exposes the accumulator, byte count and sticky overflow
// as they will be once the current byte is included; commits them on step.
module pb_varint_accum #(
  parameter int VALUE_W   = 64,
  parameter int MAX_BYTES = (VALUE_W + 6) / 7,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  input  logic               first,
  input  logic [6:0]         data,
  output logic [VALUE_W-1:0] acc_d,
  output logic [CNT_W-1:0]   cnt_d,
  output logic               ovf_d,
  output logic               last_index
);

  // One spare bit so the dropped-bit slice is never empty when VALUE_W is a multiple of 7.
  localparam int WIDE_W = 7 * MAX_BYTES + 1;

  logic [VALUE_W-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic [CNT_W-1:0]   idx;
  logic [WIDE_W-1:0]  shifted;

  always_comb begin
    idx        = first ? '0 : cnt_q;
    shifted    = {{(WIDE_W-7){1'b0}}, data} << (7 * idx);
    acc_d      = (first ? '0 : acc_q) | shifted[VALUE_W-1:0];
    ovf_d      = (first ? 1'b0 : ovf_q) | (|shifted[WIDE_W-1:VALUE_W]);
    cnt_d      = idx + CNT_W'(1);
    last_index = (idx == CNT_W'(MAX_BYTES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (step) begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/pb_varint_decoder.sv
// Streaming protobuf base-128 varint decoder: FSM, handshake and result register.
// Optional ZigZag decoding is built only when PB_VARINT_ZIGZAG_EN is defined.
module pb_varint_decoder
  import pb_pkg::*;
#(
  parameter  int VALUE_W   = 64,
  localparam int MAX_BYTES = (VALUE_W + 6) / 7,
  localparam int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  input  logic               in_zigzag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [VALUE_W-1:0] out_value,
  output logic [CNT_W-1:0]   out_nbytes,
  output logic [1:0]         out_err
);

  varint_state_e      state_q, state_d;
  logic               out_valid_q;
  logic [VALUE_W-1:0] out_value_q, value_d;
  logic [CNT_W-1:0]   out_nbytes_q;
  varint_err_e        out_err_q, err_d;

  logic               accept, first, step, emit;
  logic [VALUE_W-1:0] acc_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               ovf_d, last_index;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign first    = (state_q == ST_IDLE);
  assign step     = accept && (state_q != ST_SKIP);

  pb_varint_accum #(
    .VALUE_W   (VALUE_W),
    .MAX_BYTES (MAX_BYTES),
    .CNT_W     (CNT_W)
  ) u_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (step),
    .first      (first),
    .data       (in_data[6:0]),
    .acc_d      (acc_d),
    .cnt_d      (cnt_d),
    .ovf_d      (ovf_d),
    .last_index (last_index)
  );

`ifdef PB_VARINT_ZIGZAG_EN
  logic        zz_q;
  logic        zz_mode;
  logic [63:0] zz_full;

  always_comb begin
    zz_mode = first ? in_zigzag : zz_q;
    zz_full = zigzag_decode(64'(acc_d));
    value_d = zz_mode ? zz_full[VALUE_W-1:0] : acc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               zz_q <= 1'b0;
    else if (step && first)   zz_q <= in_zigzag;
  end
`else
  logic unused_zigzag;
  assign unused_zigzag = in_zigzag;
  assign value_d       = acc_d;
`endif

  // Truncation is tested before the index limit so it wins on the last legal byte.
  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    err_d   = VARINT_OK;
    if (accept) begin
      case (state_q)
        ST_IDLE, ST_ACCUM: begin
          if (!in_data[7]) begin
            emit    = 1'b1;
            err_d   = ovf_d ? VARINT_OVERFLOW : VARINT_OK;
            state_d = ST_IDLE;
          end else if (in_last) begin
            emit    = 1'b1;
            err_d   = VARINT_TRUNCATED;
            state_d = ST_IDLE;
          end else if (last_index) begin
            emit    = 1'b1;
            err_d   = VARINT_OVERFLOW;
            state_d = ST_SKIP;
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_SKIP: begin
          if (!in_data[7] || in_last) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      out_valid_q  <= 1'b0;
      out_value_q  <= '0;
      out_nbytes_q <= '0;
      out_err_q    <= VARINT_OK;
    end else begin
      state_q <= state_d;
      if (emit) begin
        out_valid_q  <= 1'b1;
        out_value_q  <= value_d;
        out_nbytes_q <= cnt_d;
        out_err_q    <= err_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_value  = out_value_q;
  assign out_nbytes = out_nbytes_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_pb_varint_decoder.sv
// Scoreboard bench for pb_varint_decoder at VALUE_W=64 and VALUE_W=16 fed the same byte stream.
module tb_pb_varint_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        in_zigzag = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [63:0] out_value;
  logic [3:0]  out_nbytes;
  logic [1:0]  out_err;

  logic        in_valid16, in_ready16, out_valid16;
  logic        out_ready16 = 1'b1;
  logic [15:0] out_value16;
  logic [1:0]  out_nbytes16;
  logic [1:0]  out_err16;

`ifdef PB_VARINT_ZIGZAG_EN
  localparam bit ZZ_EN = 1'b1;
`else
  localparam bit ZZ_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  pb_varint_decoder #(.VALUE_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_zigzag(in_zigzag),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_nbytes(out_nbytes), .out_err(out_err)
  );

  // The narrow instance takes a byte exactly when the wide one does.
  assign in_valid16 = in_valid && in_ready;

  pb_varint_decoder #(.VALUE_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_data(in_data), .in_last(in_last), .in_zigzag(in_zigzag),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_value(out_value16),
    .out_nbytes(out_nbytes16), .out_err(out_err16)
  );

  typedef struct {
    logic [63:0] value;
    int          nb;
    int          err;
  } exp_t;

  exp_t        q64[$];
  exp_t        q16[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          stall = 1'b0;
  logic [7:0]  vbuf [16];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = stall ? ($urandom_range(0, 3) == 0) : 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode of one whole varint held in b[0..n-1] for a result width w.
  function automatic exp_t model(input int w, input logic [7:0] b [16], input int n,
                                 input bit last, input bit zz);
    exp_t        e;
    int          maxb = (w + 6) / 7;
    logic [63:0] acc = 64'd0;
    logic [63:0] mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    bit          ovf = 1'b0;
    e.nb  = 0;
    e.err = 0;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 7; j++) begin
        if (b[k][j]) begin
          if (7 * k + j < w) acc[7 * k + j] = 1'b1;
          else               ovf = 1'b1;
        end
      end
      if (!b[k][7]) begin
        e.nb = k + 1; e.err = ovf ? 1 : 0; break;
      end
      if (k == n - 1 && last) begin
        e.nb = k + 1; e.err = 2; break;
      end
      if (k == maxb - 1) begin
        e.nb = maxb; e.err = 1; break;
      end
    end
    if (zz && ZZ_EN) acc = ((acc >> 1) ^ (acc[0] ? mask : 64'd0)) & mask;
    e.value = acc;
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit last, input bit zz);
    int waited = 0;
    in_valid  = 1'b1;
    in_data   = b;
    in_last   = last;
    in_zigzag = zz;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_varint(input int n, input bit last, input bit zz);
    q64.push_back(model(64, vbuf, n, last, zz));
    q16.push_back(model(16, vbuf, n, last, zz));
    for (int k = 0; k < n; k++) send_byte(vbuf[k], (k == n - 1) && last, zz);
  endtask

  task automatic drain();
    int t = 0;
    stall = 1'b0;
    while ((q64.size() != 0 || q16.size() != 0) && t < 300) begin
      @(posedge clk);
      t++;
    end
    chk("drain_pending", 64'(q64.size() + q16.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  bit          hold_prev = 1'b0;
  logic [63:0] held_value;
  logic [3:0]  held_nbytes;
  logic [1:0]  held_err;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
      if (hold_prev) begin
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_value", out_value, held_value);
        chk("stall_nbytes", 64'(out_nbytes), 64'(held_nbytes));
        chk("stall_err", 64'(out_err), 64'(held_err));
      end
      hold_prev   = out_valid && !out_ready;
      held_value  = out_value;
      held_nbytes = out_nbytes;
      held_err    = out_err;
      if (out_valid && out_ready) begin
        if (q64.size() == 0) chk("spurious64", {63'd0, out_valid}, 64'd0);
        else begin
          e = q64.pop_front();
          chk("value64", out_value, e.value);
          chk("nbytes64", 64'(out_nbytes), 64'(e.nb));
          chk("err64", 64'(out_err), 64'(e.err));
        end
      end
      if (out_valid16) begin
        if (q16.size() == 0) chk("spurious16", {63'd0, out_valid16}, 64'd0);
        else begin
          e = q16.pop_front();
          chk("value16", 64'(out_value16), e.value);
          chk("nbytes16", 64'(out_nbytes16), 64'(e.nb));
          chk("err16", 64'(out_err16), 64'(e.err));
        end
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    int t0;
    int n;
    bit last;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_value", out_value, 64'd0);
    chk("rst_nbytes", 64'(out_nbytes), 64'd0);
    chk("rst_err", 64'(out_err), 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_valid16", {63'd0, out_valid16}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    vbuf[0] = 8'h96; vbuf[1] = 8'h01;
    send_varint(2, 1'b0, 1'b0);
    vbuf[0] = 8'h01;
    send_varint(1, 1'b0, 1'b0);
    @(negedge clk);
    chk("latency_1cycle", {63'd0, out_valid}, 64'd1);
    @(posedge clk);
    #1;

    vbuf[0] = 8'h03; send_varint(1, 1'b0, 1'b1);
    vbuf[0] = 8'h04; send_varint(1, 1'b0, 1'b1);
    vbuf[0] = 8'h03; send_varint(1, 1'b0, 1'b0);

    for (int k = 0; k < 9; k++) vbuf[k] = 8'hFF;
    vbuf[9] = 8'h01; send_varint(10, 1'b0, 1'b0);
    vbuf[9] = 8'h7F; send_varint(10, 1'b0, 1'b0);

    for (int k = 0; k < 11; k++) vbuf[k] = 8'h80;
    vbuf[11] = 8'h00; send_varint(12, 1'b0, 1'b0);
    vbuf[0] = 8'h05; send_varint(1, 1'b0, 1'b0);

    vbuf[0] = 8'hAC; send_varint(1, 1'b1, 1'b0);

    vbuf[0] = 8'hFF; vbuf[1] = 8'hFF; vbuf[2] = 8'h03; send_varint(3, 1'b0, 1'b0);
    vbuf[2] = 8'h07; send_varint(3, 1'b0, 1'b0);
    drain();

    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      vbuf[0] = 8'(i + 9);
      send_varint(1, 1'b0, 1'b0);
    end
    chk("burst_cycles", 64'(cyc - t0), 64'd4);
    drain();

    stall = 1'b1;
    for (int v = 0; v < 100; v++) begin
      n = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 12);
      for (int k = 0; k < n; k++) vbuf[k] = {1'b1, 7'($urandom)};
      last = ($urandom_range(0, 9) == 0);
      vbuf[n-1][7] = last ? 1'($urandom) : 1'b0;
      send_varint(n, last, 1'($urandom));
    end
    drain();

    send_byte(8'h96, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_value", out_value, 64'd0);
    chk("midrst_nbytes", 64'(out_nbytes), 64'd0);
    chk("midrst_err", 64'(out_err), 64'd0);
    chk("midrst_valid16", {63'd0, out_valid16}, 64'd0);
    chk("midrst_value16", 64'(out_value16), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vbuf[0] = 8'h01;
    send_varint(1, 1'b0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pb_varint_decoder.md
# pb_varint_decoder

Streaming hardware decoder for protobuf base-128 varints, the RTL successor to the package-level software decode routines. It consumes one wire byte per handshake and emits one decoded integer per varint, with parametrised result width, optional ZigZag (sint) decoding, a truncation flag for varints cut off by end of message, and an overflow flag for overlong varints. It sits between the byte-stream front end and the field dispatcher of the hardware message parser.

## Interface
- VALUE_W, 64: decoded value width; legal 8..64.
- MAX_BYTES, (VALUE_W+6)/7: maximum varint length; derived, not overridden.
- CNT_W, $clog2(MAX_BYTES+1): byte-count width; derived.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  byte available.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- in_data  in  8  wire byte; bit 7 is the continuation bit.
- in_last  in  1  byte is the final byte of the enclosing message.
- in_zigzag  in  1  decode as ZigZag; sampled on the first byte of each varint.
- out_valid  out  1  result held.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_value  out  VALUE_W  decoded value.
- out_nbytes  out  CNT_W  bytes consumed by this varint (1..MAX_BYTES).
- out_err  out  2  0 = ok, 1 = overflow, 2 = truncated.

## Operation
- States: IDLE (no partial varint), ACCUM (partial varint), SKIP (discarding the tail of an overlong varint).
- Accept rule: in_ready = !out_valid | out_ready. This holds in every state, including SKIP.
- Accepted byte k (0-based) ORs in_data[6:0] << 7k into the accumulator. Bits at positions >= VALUE_W are dropped, and any dropped 1 sets a sticky overflow flag.
- IDLE: the first byte latches the zigzag mode and clears the accumulator, count and flags. If bit7=0, it emits immediately. If bit7=1, the next state is ACCUM.
- ACCUM: a byte with bit7=0 emits and returns to IDLE.
- Overlong varint: if the byte at index MAX_BYTES-1 has bit7=1, the block emits the partial value with out_err=1 and out_nbytes=MAX_BYTES, then enters SKIP.
- SKIP: consumes bytes without emitting. A byte with bit7=0 or in_last=1 returns to IDLE.
- Truncation: in_last=1 on a byte with bit7=1 while in IDLE or ACCUM emits the partial value with out_err=2 and returns to IDLE.
- Error priority:
  - A sticky overflow on the terminating byte emits with err=1.
  - Truncation outranks the index-limit overflow.
- ZigZag: out_value = (acc >> 1) ^ -(acc[0]). It applies to the whole VALUE_W result, including error emissions.
- Unsigned result: out_value = acc, zero-extended.

## Timing
- Reset: out_valid=0, out_value=0, out_nbytes=0, out_err=0, state=IDLE, accumulator and count=0.
- in_ready is combinational from out_valid and out_ready only. There is no combinational path from in_valid to in_ready.
- Latency: the result is registered; out_valid rises the cycle after the terminating byte is accepted.
- Throughput: one byte per cycle. Back-to-back one-byte varints give one result per cycle when out_ready is held at 1.
- Once out_valid=1, out_value, out_nbytes and out_err hold stable until the result is consumed.
- Simultaneous consume and new terminating byte in the same cycle: out_valid stays 1 and the new result is loaded.
- Reset mid-varint discards the partial state. No result is emitted.

## Configuration
- PB_VARINT_ZIGZAG_EN defined: in_zigzag is honoured as above.
- PB_VARINT_ZIGZAG_EN undefined: in_zigzag is ignored, the ZigZag datapath is absent, and all results are unsigned. The port remains so instances are unchanged.

## Structure
- Add to pb_pkg:
  - varint_err_e: VARINT_OK=0, VARINT_OVERFLOW=1, VARINT_TRUNCATED=2.
  - The existing MAX_VARINT_BYTES constant, as the VALUE_W=64 bound.
  - A function zigzag_decode.
- One sub-module, pb_varint_accum: the shift/OR datapath, count and sticky overflow.
- pb_varint_decoder keeps the FSM, handshake and output register.

## Test plan
- 0x96,0x01 (unsigned) -> out_value=150, nbytes=2, err=0. Then 0x01 -> value 1, nbytes 1, valid the cycle after.
- 0x03 with in_zigzag=1 -> value 0xFFFF_FFFF_FFFF_FFFE (-2). 0x04 -> 2. With the macro undefined, 0x03 -> 3.
- Nine 0xFF then 0x01 at VALUE_W=64 -> 0xFFFF_FFFF_FFFF_FFFF, nbytes=10, err=0. Nine 0xFF then 0x7F -> err=1.
- Ten 0x80 then 0x80,0x00 -> one emission with err=1 and nbytes=10. The tail is skipped, and the next 0x05 -> value 5.
- 0xAC with in_last=1 -> value 0x2C, nbytes 1, err=2. At VALUE_W=16, 0xFF,0xFF,0x03 -> 0xFFFF, err=0. At VALUE_W=16, 0xFF,0xFF,0x07 -> err=1.
- Hold out_ready=0 over a 100-varint random stream:
  - in_ready drops while out_valid=1.
  - No result is lost or duplicated.
  - Outputs stay stable during the stall.
  - Assert rst_n mid-varint -> all outputs 0 and no emission.
